// File: rtl/gyro_axis_scheduler.sv
// gyro_axis_scheduler
// Steps the downstream 3:1 mux through X, Y and Z on every new gyro sample.
// After SETTLE_CYCLES of stable select it captures the mux word, tags it with
// its axis, and hands it to the consumer over a valid/ready handshake.
// Optional build macro: GYRO_AXIS_SCHED_TEMP_EN adds a fourth slot (sel=11, temperature).
// A sample that arrives while a frame is in flight is remembered in a
// one-deep pending flag. A further sample while that flag is set is dropped
// and reported on overrun.
module gyro_axis_scheduler #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [15:0] data_in,
   output logic [1:0]  sel,
   output logic [15:0] out_data,
   output logic [1:0]  out_tag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETTLE  = 2'd1;
   localparam logic [1:0] ST_PRESENT = 2'd2;

   localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

`ifdef GYRO_AXIS_SCHED_TEMP_EN
   localparam logic [1:0] LAST_SEL = 2'b11;
`else
   localparam logic [1:0] LAST_SEL = 2'b10;
`endif

   logic [1:0]  state_reg, state_next;
   logic [1:0]  sel_reg, sel_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [15:0] data_reg, data_next;
   logic [1:0]  tag_reg, tag_next;
   logic        valid_reg, valid_next;
   logic        busy_reg, busy_next;
   logic        frame_done_reg, frame_done_next;
   logic        pending_reg, pending_next;
   logic        overrun_reg, overrun_next;

   logic handshake;
   logic frame_end;
   logic in_frame;

   assign handshake = (state_reg == ST_PRESENT) && valid_reg && out_ready;
   assign frame_end = handshake && (sel_reg == LAST_SEL);
   assign in_frame  = (state_reg != ST_IDLE);

   // Frame sequencing: select stepping, settle countdown, capture and handshake
   always_comb begin
      state_next      = state_reg;
      sel_next        = sel_reg;
      cnt_next        = cnt_reg;
      data_next       = data_reg;
      tag_next        = tag_reg;
      valid_next      = valid_reg;
      frame_done_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (sample_valid) begin
               sel_next   = 2'b00;
               cnt_next   = CNT_RELOAD;
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               data_next  = data_in;
               tag_next   = sel_reg;
               valid_next = 1'b1;
               state_next = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (handshake) begin
               valid_next = 1'b0;
               if (sel_reg != LAST_SEL) begin
                  sel_next   = sel_reg + 2'd1;
                  cnt_next   = CNT_RELOAD;
                  state_next = ST_SETTLE;
               end else begin
                  frame_done_next = 1'b1;
                  // Back-to-back frame: either the remembered sample or
                  // the one arriving right now starts the next frame.
                  if (pending_reg || sample_valid) begin
                     sel_next   = 2'b00;
                     cnt_next   = CNT_RELOAD;
                     state_next = ST_SETTLE;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   // Pending/overrun bookkeeping for samples arriving mid-frame
   always_comb begin
      pending_next = pending_reg;
      overrun_next = 1'b0;
      if (frame_end) begin
         // The restart consumes the pending sample if there is one;
         // a coincident new sample then becomes the pending one.
         // Without a pending sample the coincident one is consumed directly.
         pending_next = pending_reg && sample_valid;
      end else if (in_frame && sample_valid) begin
         if (pending_reg) begin
            overrun_next = 1'b1;
         end else begin
            pending_next = 1'b1;
         end
      end
   end

   // State and output registers, cleared immediately by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         sel_reg        <= 2'b00;
         cnt_reg        <= 4'd0;
         data_reg       <= 16'h0000;
         tag_reg        <= 2'b00;
         valid_reg      <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         pending_reg    <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         sel_reg        <= sel_next;
         cnt_reg        <= cnt_next;
         data_reg       <= data_next;
         tag_reg        <= tag_next;
         valid_reg      <= valid_next;
         busy_reg       <= busy_next;
         frame_done_reg <= frame_done_next;
         pending_reg    <= pending_next;
         overrun_reg    <= overrun_next;
      end
   end

   assign sel        = sel_reg;
   assign out_data   = data_reg;
   assign out_tag    = tag_reg;
   assign out_valid  = valid_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_gyro_axis_scheduler.sv
// Self-checking bench for gyro_axis_scheduler.
// Default build: vector tables for a single frame and a pending/overrun
// frame pair, plus hand-written back-pressure, coincident-sample and
// mid-frame reset sequences. Both builds run a generic frame cadence check
// (GYRO_AXIS_SCHED_TEMP_EN selects four slots and SETTLE_CYCLES=3).
module tb_gyro_axis_scheduler;

`ifdef GYRO_AXIS_SCHED_TEMP_EN
   localparam int SC = 3;
   localparam int NS = 4;
`else
   localparam int SC = 1;
   localparam int NS = 3;
`endif

   logic        clk;
   logic        rst_n;
   logic        sample_valid;
   logic [15:0] data_in;
   logic [1:0]  sel;
   logic [15:0] out_data;
   logic [1:0]  out_tag;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   gyro_axis_scheduler #(.SETTLE_CYCLES(SC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .data_in      (data_in),
      .sel          (sel),
      .out_data     (out_data),
      .out_tag      (out_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mux model: the word depends only on the select
   always_comb begin
      case (sel)
         2'b00:   data_in = 16'h1111;
         2'b01:   data_in = 16'h2222;
         2'b10:   data_in = 16'h3333;
         default: data_in = 16'h4444;
      endcase
   end

   typedef struct {
      logic        sv;
      logic        rdy;
      logic [1:0]  sel;
      logic        vld;
      logic [15:0] data;
      logic [1:0]  tag;
      logic        busy;
      logic        fd;
      logic        ov;
   } vec_t;

   vec_t vecs[24];
   int   nvec = 0;

   task automatic add_vec(input logic sv_i, input logic rdy_i, input logic [1:0] sel_i,
                          input logic vld_i, input logic [15:0] data_i, input logic [1:0] tag_i,
                          input logic busy_i, input logic fd_i, input logic ov_i);
      vecs[nvec].sv   = sv_i;
      vecs[nvec].rdy  = rdy_i;
      vecs[nvec].sel  = sel_i;
      vecs[nvec].vld  = vld_i;
      vecs[nvec].data = data_i;
      vecs[nvec].tag  = tag_i;
      vecs[nvec].busy = busy_i;
      vecs[nvec].fd   = fd_i;
      vecs[nvec].ov   = ov_i;
      nvec++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tagname);
      check({tagname, ".sel"},        32'(sel), 32'h0);
      check({tagname, ".out_data"},   32'(out_data), 32'h0);
      check({tagname, ".out_tag"},    32'(out_tag), 32'h0);
      check({tagname, ".out_valid"},  32'(out_valid), 32'h0);
      check({tagname, ".busy"},       32'(busy), 32'h0);
      check({tagname, ".frame_done"}, 32'(frame_done), 32'h0);
      check({tagname, ".overrun"},    32'(overrun), 32'h0);
   endtask

   initial begin
      int last_v;
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      out_ready    = 1'b0;
      #12;
      check_reset_values("reset");
      $display("reset: sel=%0h out_valid=%0b busy=%0b", sel, out_valid, busy);
      #1;
      rst_n = 1'b1;
      tick();

`ifndef GYRO_AXIS_SCHED_TEMP_EN
      // Single frame, out_ready high (rows 0..8)
      add_vec(1'b1, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd0, 1'b1, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd1, 1'b0, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd1, 1'b1, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b1, 16'h3333, 2'd2, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b0, 16'h3333, 2'd2, 1'b0, 1'b1, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b0, 16'h3333, 2'd2, 1'b0, 1'b0, 1'b0);
      // Pending + overrun, then back-to-back second frame, then idle
      add_vec(1'b1, 1'b1, 2'd2, 1'b0, 16'h3333, 2'd2, 1'b0, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd0, 1'b0, 16'h3333, 2'd2, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd0, 1'b1, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b1, 1'b1, 2'd1, 1'b0, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b1, 1'b1, 2'd1, 1'b1, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b1);
      add_vec(1'b0, 1'b1, 2'd2, 1'b1, 16'h3333, 2'd2, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd0, 1'b0, 16'h3333, 2'd2, 1'b1, 1'b1, 1'b0);
      add_vec(1'b0, 1'b1, 2'd0, 1'b1, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd1, 1'b0, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd1, 1'b1, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b1, 16'h3333, 2'd2, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b0, 16'h3333, 2'd2, 1'b0, 1'b1, 1'b0);
      add_vec(1'b0, 1'b1, 2'd2, 1'b0, 16'h3333, 2'd2, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < nvec; i++) begin
         sample_valid = vecs[i].sv;
         out_ready    = vecs[i].rdy;
         check($sformatf("vec%0d.sel", i),        32'(sel),        32'(vecs[i].sel));
         check($sformatf("vec%0d.out_valid", i),  32'(out_valid),  32'(vecs[i].vld));
         check($sformatf("vec%0d.out_data", i),   32'(out_data),   32'(vecs[i].data));
         check($sformatf("vec%0d.out_tag", i),    32'(out_tag),    32'(vecs[i].tag));
         check($sformatf("vec%0d.busy", i),       32'(busy),       32'(vecs[i].busy));
         check($sformatf("vec%0d.frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
         check($sformatf("vec%0d.overrun", i),    32'(overrun),    32'(vecs[i].ov));
         $display("vec %0d: sv=%0b rdy=%0b sel=%0h vld=%0b data=%04h tag=%0h busy=%0b fd=%0b ov=%0b",
                  i, sample_valid, out_ready, sel, out_valid, out_data, out_tag, busy, frame_done, overrun);
         tick();
      end
      sample_valid = 1'b0;

      // Back-pressure on the Y word
      sample_valid = 1'b1; out_ready = 1'b1;
      tick(); sample_valid = 1'b0;
      tick(); tick(); tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp.out_valid", 32'(out_valid), 32'h1);
         check("bp.out_data",  32'(out_data),  32'h2222);
         check("bp.out_tag",   32'(out_tag),   32'h1);
         check("bp.sel",       32'(sel),       32'h1);
         $display("bp stall %0d: vld=%0b data=%04h tag=%0h sel=%0h", i, out_valid, out_data, out_tag, sel);
         tick();
      end
      out_ready = 1'b1;
      check("bp.release_valid", 32'(out_valid), 32'h1);
      tick();
      check("bp.z_settle_valid", 32'(out_valid), 32'h0);
      check("bp.z_settle_sel",   32'(sel),       32'h2);
      tick();
      check("bp.z_valid", 32'(out_valid), 32'h1);
      check("bp.z_data",  32'(out_data),  32'h3333);
      check("bp.z_tag",   32'(out_tag),   32'h2);
      $display("bp Z word: data=%04h tag=%0h", out_data, out_tag);
      tick();
      check("bp.frame_done", 32'(frame_done), 32'h1);
      tick();

      // Sample coincident with the Z handshake, nothing pending
      sample_valid = 1'b1;
      tick(); sample_valid = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      check("sim.z_valid", 32'(out_valid), 32'h1);
      check("sim.z_tag",   32'(out_tag),   32'h2);
      sample_valid = 1'b1;
      tick(); sample_valid = 1'b0;
      check("sim.sel",        32'(sel),        32'h0);
      check("sim.frame_done", 32'(frame_done), 32'h1);
      check("sim.busy",       32'(busy),       32'h1);
      check("sim.overrun",    32'(overrun),    32'h0);
      tick();
      check("sim.x_valid", 32'(out_valid), 32'h1);
      check("sim.x_data",  32'(out_data),  32'h1111);
      $display("sim restart: sel=%0h fd=%0b data=%04h", sel, frame_done, out_data);
      tick(); tick(); tick(); tick();
      check("sim.z2_valid", 32'(out_valid), 32'h1);
      check("sim.z2_tag",   32'(out_tag),   32'h2);
      tick();
      check("sim.end_fd",   32'(frame_done), 32'h1);
      check("sim.end_busy", 32'(busy),       32'h0);
      tick();
      check("sim.idle_busy", 32'(busy), 32'h0);
      check("sim.idle_ov",   32'(overrun), 32'h0);

      // Reset asserted while Y is settling
      sample_valid = 1'b1;
      tick(); sample_valid = 1'b0;
      tick();
      check("rst.x_valid", 32'(out_valid), 32'h1);
      tick();
      check("rst.y_settle_sel", 32'(sel), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      $display("mid-frame reset: sel=%0h data=%04h vld=%0b busy=%0b", sel, out_data, out_valid, busy);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      check_reset_values("postreset");
      sample_valid = 1'b1;
      tick(); sample_valid = 1'b0;
      check("rst.new_busy", 32'(busy), 32'h1);
      check("rst.new_sel",  32'(sel),  32'h0);
      tick();
      check("rst.new_valid", 32'(out_valid), 32'h1);
      check("rst.new_data",  32'(out_data),  32'h1111);
      check("rst.new_tag",   32'(out_tag),   32'h0);
      $display("post-reset frame: data=%04h tag=%0h", out_data, out_tag);
      tick(); tick(); tick(); tick(); tick();
`endif

      // Generic cadence: word k valid at 1+SC+k*(SC+1), frame_done one cycle after the last
      out_ready = 1'b1;
      last_v = 1 + SC + (NS - 1) * (SC + 1);
      sample_valid = 1'b1;
      tick(); sample_valid = 1'b0;
      for (int c = 1; c <= last_v + 2; c++) begin
         logic exp_v;
         int   k;
         exp_v = 1'b0;
         k     = 0;
         if (c >= 1 + SC && c <= last_v && ((c - 1 - SC) % (SC + 1)) == 0) begin
            exp_v = 1'b1;
            k     = (c - 1 - SC) / (SC + 1);
         end
         check($sformatf("cad%0d.out_valid", c), 32'(out_valid), 32'(exp_v));
         check($sformatf("cad%0d.frame_done", c), 32'(frame_done), (c == last_v + 1) ? 32'h1 : 32'h0);
         if (exp_v) begin
            check($sformatf("cad%0d.out_tag", c), 32'(out_tag), 32'(k));
            check($sformatf("cad%0d.out_data", c), 32'(out_data), 32'h1111 * (k + 1));
         end
         $display("cadence cycle %0d: vld=%0b tag=%0h data=%04h fd=%0b busy=%0b",
                  c, out_valid, out_tag, out_data, frame_done, busy);
         tick();
      end
      check("cad.idle_busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
